// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester, grant and data-memory signals of dmem_arbiter.
// lock0/lock1 exist only when DMEM_ARB_BURST_EN is defined.
interface dmem_arbiter_if #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32
);
  logic req0, req1, wrtEn0, wrtEn1;
  logic [ADDR_BIT_WIDTH-1:0] addr0, addr1, memAddr;
  logic [DATA_BIT_WIDTH-1:0] dIn0, dIn1, dOut0, dOut1, memDIn, memDOut;
  logic gnt0, gnt1, rdValid0, rdValid1, memWrtEn;
`ifdef DMEM_ARB_BURST_EN
  logic lock0, lock1;
`endif
  modport slave (
    input req0, req1, wrtEn0, wrtEn1, addr0, addr1, dIn0, dIn1, memDOut,
`ifdef DMEM_ARB_BURST_EN
    input lock0, lock1,
`endif
    output gnt0, gnt1, rdValid0, rdValid1, dOut0, dOut1, memWrtEn, memAddr, memDIn
  );
  modport master (
    output req0, req1, wrtEn0, wrtEn1, addr0, addr1, dIn0, dIn1, memDOut,
`ifdef DMEM_ARB_BURST_EN
    output lock0, lock1,
`endif
    input gnt0, gnt1, rdValid0, rdValid1, dOut0, dOut1, memWrtEn, memAddr, memDIn
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter sharing one data memory port.
// Define DMEM_ARB_BURST_EN to let a locked owner hold the port for up to MAX_BURST grants.
module dmem_arbiter #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32
`ifdef DMEM_ARB_BURST_EN
  ,
  parameter int MAX_BURST = 4
`endif
) (
  input logic clk,
  input logic resetN,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t r_state, w_next;
  logic r_last, w_keep0, w_keep1, w_elig0, w_elig1, w_rd0, w_rd1, r_rdv0, r_rdv1;
  logic [ADDR_BIT_WIDTH-1:0] w_addr;
  logic [DATA_BIT_WIDTH-1:0] w_din, r_dout0, r_dout1;
`ifdef DMEM_ARB_BURST_EN
  logic [3:0] r_cnt;
  // A locked owner still under its burst limit is regranted ahead of the other port.
  always_comb begin
    w_keep0 = r_state == OWN0 && bus.lock0 && bus.req0 && r_cnt < 4'(MAX_BURST);
    w_keep1 = r_state == OWN1 && bus.lock1 && bus.req1 && r_cnt < 4'(MAX_BURST);
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) r_cnt <= 4'd0;
    else r_cnt <= w_next == IDLE ? 4'd0 : w_next != r_state ? 4'd1 : r_cnt + 4'd1;
`else
  always_comb begin
    w_keep0 = 1'b0;
    w_keep1 = 1'b0;
  end
`endif
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      r_state <= IDLE;
      r_last <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next != IDLE) r_last <= w_next == OWN1;
    end
  always_comb begin
    w_elig0 = bus.req0 && (r_state != OWN0 || w_keep0);
    w_elig1 = bus.req1 && (r_state != OWN1 || w_keep1);
    w_next = w_keep0 ? OWN0 : w_keep1 ? OWN1 :
             (w_elig0 && w_elig1) ? (r_last ? OWN0 : OWN1) :
             w_elig0 ? OWN0 : w_elig1 ? OWN1 : IDLE;
  end
  always_comb begin
    bus.gnt0 = r_state == OWN0;
    bus.gnt1 = r_state == OWN1;
    w_addr = r_state == OWN0 ? bus.addr0 : r_state == OWN1 ? bus.addr1 : '0;
    w_din = r_state == OWN0 ? bus.dIn0 : r_state == OWN1 ? bus.dIn1 : '0;
    bus.memWrtEn = r_state == OWN0 ? bus.wrtEn0 & bus.req0 :
                   r_state == OWN1 ? bus.wrtEn1 & bus.req1 : 1'b0;
    bus.memAddr = w_addr;
    bus.memDIn = w_din;
    w_rd0 = r_state == OWN0 && bus.req0 && !bus.wrtEn0;
    w_rd1 = r_state == OWN1 && bus.req1 && !bus.wrtEn1;
    bus.rdValid0 = r_rdv0;
    bus.rdValid1 = r_rdv1;
    bus.dOut0 = r_dout0;
    bus.dOut1 = r_dout1;
  end
  // A dropped request during its grant cycle completes nothing, so no strobe and no capture.
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      r_rdv0 <= 1'b0;
      r_rdv1 <= 1'b0;
      r_dout0 <= '0;
      r_dout1 <= '0;
    end else begin
      r_rdv0 <= w_rd0;
      r_rdv1 <= w_rd1;
      if (w_rd0) r_dout0 <= bus.memDOut;
      if (w_rd1) r_dout1 <= bus.memDOut;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, hand-written corner sequences and a randomized
// run of dmem_arbiter against a transaction-level reference model.
module tb_dmem_arbiter;
  logic clk = 1'b0, resetN = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();
  dmem_arbiter dut (.clk(clk), .resetN(resetN), .bus(bus));

  logic rq[2], wr[2];
  logic [31:0] ad[2], dn[2];
  assign bus.req0 = rq[0];
  assign bus.req1 = rq[1];
  assign bus.wrtEn0 = wr[0];
  assign bus.wrtEn1 = wr[1];
  assign bus.addr0 = ad[0];
  assign bus.addr1 = ad[1];
  assign bus.dIn0 = dn[0];
  assign bus.dIn1 = dn[1];
`ifdef DMEM_ARB_BURST_EN
  logic lk[2];
  assign bus.lock0 = lk[0];
  assign bus.lock1 = lk[1];
`endif

  logic [31:0] mem[16];
  logic pre_we = 1'b0;
  logic [3:0] pre_a = 4'd0;
  logic [31:0] pre_d = 32'd0;
  assign bus.memDOut = mem[bus.memAddr[5:2]];
  always @(posedge clk)
    if (bus.memWrtEn) mem[bus.memAddr[5:2]] <= bus.memDIn;
    else if (pre_we) mem[pre_a] <= pre_d;

  int checks = 0, errors = 0;
  int m_own, m_last;
  logic [31:0] ref_mem[16];
  logic [31:0] exp_dout[2];

  typedef struct {
    logic r0, r1, w1;
    logic g0, g1, we;
    logic [31:0] ma, md;
    logic rv1;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    pre_we = 1'b1;
    pre_a = 4'(a);
    pre_d = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    rq[0] = 1'b0; rq[1] = 1'b0; wr[0] = 1'b0; wr[1] = 1'b0;
    ad[0] = 32'd0; ad[1] = 32'd0; dn[0] = 32'd0; dn[1] = 32'd0;
`ifdef DMEM_ARB_BURST_EN
    lk[0] = 1'b0; lk[1] = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) resetN = 1'b1;
    m_own = -1;
    m_last = 1;
    exp_dout[0] = 32'd0;
    exp_dout[1] = 32'd0;
  endtask

  initial begin
    #2;
    do_reset();
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_rdv0", bus.rdValid0, 0);
    chk("rst_rdv1", bus.rdValid1, 0);
    chk("rst_dout0", bus.dOut0, 0);
    chk("rst_dout1", bus.dOut1, 0);
    chk("rst_we", bus.memWrtEn, 0);
    chk("rst_addr", bus.memAddr, 0);
    chk("rst_din", bus.memDIn, 0);

    // two writers alternating, then port 1 reading alone every other cycle
    tbl[0]  = '{1, 1, 1, 1, 0, 1, 32'h20, 32'h11111111, 0};
    tbl[1]  = '{1, 1, 1, 0, 1, 1, 32'h24, 32'h22222222, 0};
    tbl[2]  = '{1, 1, 1, 1, 0, 1, 32'h20, 32'h11111111, 0};
    tbl[3]  = '{1, 1, 1, 0, 1, 1, 32'h24, 32'h22222222, 0};
    tbl[4]  = '{0, 1, 1, 0, 0, 0, 32'h0, 32'h0, 0};
    tbl[5]  = '{0, 1, 0, 0, 1, 0, 32'h24, 32'h22222222, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 1};
    tbl[7]  = '{0, 1, 0, 0, 1, 0, 32'h24, 32'h22222222, 0};
    tbl[8]  = '{0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 1};
    tbl[9]  = '{0, 1, 0, 0, 1, 0, 32'h24, 32'h22222222, 0};
    tbl[10] = '{0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 1};
    wr[0] = 1'b1; ad[0] = 32'h20; dn[0] = 32'h11111111;
    ad[1] = 32'h24; dn[1] = 32'h22222222;
    for (int i = 0; i < 11; i++) begin
      rq[0] = tbl[i].r0; rq[1] = tbl[i].r1; wr[1] = tbl[i].w1;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_gnt0", i), bus.gnt0, tbl[i].g0);
      chk($sformatf("tbl%0d_gnt1", i), bus.gnt1, tbl[i].g1);
      chk($sformatf("tbl%0d_we", i), bus.memWrtEn, tbl[i].we);
      chk($sformatf("tbl%0d_addr", i), bus.memAddr, tbl[i].ma);
      chk($sformatf("tbl%0d_din", i), bus.memDIn, tbl[i].md);
      chk($sformatf("tbl%0d_rdv1", i), bus.rdValid1, tbl[i].rv1);
    end
    rq[0] = 1'b0; rq[1] = 1'b0;
    chk("tbl_dout1", bus.dOut1, 32'h22222222);
    chk("tbl_mem20", mem[8], 32'h11111111);
    chk("tbl_mem24", mem[9], 32'h22222222);

    // single read from port 0
    preload(4, 32'hDEADBEEF);
    preload(5, 32'h55555555);
    rq[0] = 1'b1; wr[0] = 1'b0; ad[0] = 32'h10;
    @(posedge clk); #1;
    chk("rd_gnt0", bus.gnt0, 1);
    chk("rd_gnt1", bus.gnt1, 0);
    chk("rd_addr", bus.memAddr, 32'h10);
    chk("rd_rdv0_early", bus.rdValid0, 0);
    @(posedge clk); #1;
    chk("rd_rdv0", bus.rdValid0, 1);
    chk("rd_dout0", bus.dOut0, 32'hDEADBEEF);
    chk("rd_gnt0_off", bus.gnt0, 0);
    chk("rd_gnt1_off", bus.gnt1, 0);
    rq[0] = 1'b0;
    @(posedge clk); #1;
    chk("rd_rdv0_once", bus.rdValid0, 0);
    chk("rd_dout0_hold", bus.dOut0, 32'hDEADBEEF);

    // asynchronous reset in the middle of a write grant
    do_reset();
    preload(12, 32'h12345678);
    rq[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'h30; dn[0] = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("ar_gnt0", bus.gnt0, 1);
    chk("ar_we", bus.memWrtEn, 1);
    #2 resetN = 1'b0;
    #1;
    chk("ar_gnt0_async", bus.gnt0, 0);
    chk("ar_we_async", bus.memWrtEn, 0);
    rq[0] = 1'b0;
    @(posedge clk);
    @(negedge clk) resetN = 1'b1;
    @(posedge clk); #1;
    chk("ar_gnt0_after", bus.gnt0, 0);
    chk("ar_gnt1_after", bus.gnt1, 0);
    chk("ar_mem_kept", mem[12], 32'h12345678);

    // request dropped during its own grant cycle
    rq[0] = 1'b1; wr[0] = 1'b0; ad[0] = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    chk("pv_dout0_setup", bus.dOut0, 32'hDEADBEEF);
    rq[0] = 1'b0;
    @(posedge clk); #1;
    rq[0] = 1'b1; ad[0] = 32'h14;
    @(posedge clk); #1;
    chk("pv_gnt0", bus.gnt0, 1);
    rq[0] = 1'b0;
    rq[1] = 1'b1; wr[1] = 1'b1; ad[1] = 32'h28; dn[1] = 32'hA5A5A5A5;
    chk("pv_we_dropped", bus.memWrtEn, 0);
    @(posedge clk); #1;
    chk("pv_rdv0", bus.rdValid0, 0);
    chk("pv_dout0_hold", bus.dOut0, 32'hDEADBEEF);
    chk("pv_gnt1", bus.gnt1, 1);
    chk("pv_we1", bus.memWrtEn, 1);
    chk("pv_addr1", bus.memAddr, 32'h28);
    @(posedge clk); #1;
    rq[1] = 1'b0;
    chk("pv_mem28", mem[10], 32'hA5A5A5A5);

`ifdef DMEM_ARB_BURST_EN
    begin
      logic exp_g0[6];
      exp_g0 = '{1, 1, 1, 1, 0, 1};
      do_reset();
      lk[0] = 1'b1; rq[0] = 1'b1; wr[0] = 1'b0; ad[0] = 32'h10;
      rq[1] = 1'b1; wr[1] = 1'b1; ad[1] = 32'h2C; dn[1] = 32'h0F0F0F0F;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        chk($sformatf("burst%0d_gnt0", i), bus.gnt0, exp_g0[i]);
        chk($sformatf("burst%0d_gnt1", i), bus.gnt1, !exp_g0[i]);
      end
      do_reset();
    end
`endif

    // randomized traffic against the transaction-level model
    do_reset();
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    for (int c = 0; c < 400; c++) begin
      int own, nxt, done;
      logic el0, el1;
      logic rv[2];
      for (int p = 0; p < 2; p++)
        if (!rq[p] && $urandom_range(0, 1) == 1) begin
          rq[p] = 1'b1;
          wr[p] = 1'($urandom_range(0, 1));
          ad[p] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
          dn[p] = $urandom;
        end
      #1;
      own = m_own;
      if (own >= 0) begin
        chk("rnd_we", bus.memWrtEn, wr[own] & rq[own]);
        chk("rnd_addr", bus.memAddr, ad[own]);
        chk("rnd_din", bus.memDIn, dn[own]);
      end else begin
        chk("rnd_we_idle", bus.memWrtEn, 0);
        chk("rnd_addr_idle", bus.memAddr, 0);
      end
      done = -1;
      rv[0] = 1'b0; rv[1] = 1'b0;
      if (own >= 0 && rq[own]) begin
        done = own;
        if (wr[own]) ref_mem[ad[own][5:2]] = dn[own];
        else begin
          exp_dout[own] = ref_mem[ad[own][5:2]];
          rv[own] = 1'b1;
        end
      end
      el0 = rq[0] && own != 0;
      el1 = rq[1] && own != 1;
      nxt = (el0 && el1) ? (m_last == 0 ? 1 : 0) : el0 ? 0 : el1 ? 1 : -1;
      if (nxt >= 0) m_last = nxt;
      m_own = nxt;
      @(posedge clk); #1;
      chk("rnd_gnt0", bus.gnt0, m_own == 0);
      chk("rnd_gnt1", bus.gnt1, m_own == 1);
      chk("rnd_rdv0", bus.rdValid0, rv[0]);
      chk("rnd_rdv1", bus.rdValid1, rv[1]);
      chk("rnd_dout0", bus.dOut0, exp_dout[0]);
      chk("rnd_dout1", bus.dOut1, exp_dout[1]);
      if (done >= 0) begin
        if ($urandom_range(0, 1) == 1) rq[done] = 1'b0;
        else begin
          wr[done] = 1'($urandom_range(0, 1));
          ad[done] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
          dn[done] = $urandom;
        end
      end
    end
    rq[0] = 1'b0; rq[1] = 1'b0;
    for (int i = 0; i < 16; i++) chk($sformatf("rnd_mem%0d", i), mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
